// File: rtl/skylark_mem_arbiter_if.sv
// Fetch/data request ports plus shared memory port of skylark_mem_arbiter.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface skylark_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          if_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          d_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, if_err, d_rdata, d_valid, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, if_err, d_rdata, d_valid, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/skylark_mem_arbiter.sv
// Fetch/data arbiter onto one variable-latency memory; 2+wait cycles request-to-pulse, TIMEOUT watchdog.
// Requests are held until the *_valid pulse; SKYLARK_ARB_RR_EN selects round-robin over data-first priority.
module skylark_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  skylark_mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_IF_ACC, S_D_ACC} state_t;

  state_t        r_state,     w_state_nxt;
  logic [CW-1:0] r_cnt,       w_cnt_nxt;
  logic          r_mem_req,   w_mem_req_nxt;
  logic          r_mem_we,    w_mem_we_nxt;
  logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DW-1:0] r_if_rdata,  w_if_rdata_nxt;
  logic          r_if_valid,  w_if_valid_nxt;
  logic          r_if_err,    w_if_err_nxt;
  logic [DW-1:0] r_d_rdata,   w_d_rdata_nxt;
  logic          r_d_valid,   w_d_valid_nxt;
  logic          r_d_err,     w_d_err_nxt;

  logic w_if_cand, w_d_cand, w_pick_d, w_pick_if;

  // A requester still holding its request during its own completion pulse is not re-granted.
  assign w_if_cand = bus.if_req & ~r_if_valid;
  assign w_d_cand  = bus.d_req  & ~r_d_valid;

`ifdef SKYLARK_ARB_RR_EN
  logic r_last_d;

  assign w_pick_d = w_d_cand & (~w_if_cand | ~r_last_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b1;
    end else if (r_state == S_IDLE && (w_if_cand || w_d_cand)) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = w_d_cand;
`endif

  assign w_pick_if = w_if_cand & ~w_pick_d;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_rdata_nxt  = r_if_rdata;
    w_if_valid_nxt  = 1'b0;
    w_if_err_nxt    = 1'b0;
    w_d_rdata_nxt   = r_d_rdata;
    w_d_valid_nxt   = 1'b0;
    w_d_err_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_pick_d) begin
          w_state_nxt     = S_D_ACC;
          w_cnt_nxt       = '0;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = bus.d_we;
          w_mem_addr_nxt  = bus.d_addr;
          w_mem_wdata_nxt = bus.d_wdata;
        end else if (w_pick_if) begin
          w_state_nxt    = S_IF_ACC;
          w_cnt_nxt      = '0;
          w_mem_req_nxt  = 1'b1;
          w_mem_we_nxt   = 1'b0;
          w_mem_addr_nxt = bus.if_addr;
        end
      end
      S_IF_ACC, S_D_ACC: begin
        if (bus.mem_ready) begin
          w_state_nxt   = S_IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          if (r_state == S_IF_ACC) begin
            w_if_valid_nxt = 1'b1;
            w_if_rdata_nxt = bus.mem_rdata;
          end else begin
            w_d_valid_nxt = 1'b1;
            if (!r_mem_we) w_d_rdata_nxt = bus.mem_rdata;
          end
        end else if (r_cnt == CW'(TIMEOUT)) begin
          w_state_nxt   = S_IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          if (r_state == S_IF_ACC) begin
            w_if_valid_nxt = 1'b1;
            w_if_err_nxt   = 1'b1;
          end else begin
            w_d_valid_nxt = 1'b1;
            w_d_err_nxt   = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_if_err    <= 1'b0;
      r_d_rdata   <= '0;
      r_d_valid   <= 1'b0;
      r_d_err     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_if_err    <= w_if_err_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_d_valid   <= w_d_valid_nxt;
      r_d_err     <= w_d_err_nxt;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_err    = r_if_err;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_valid   = r_d_valid;
  assign bus.d_err     = r_d_err;
endmodule

// File: tb/tb_skylark_mem_arbiter.sv
// Directed bench for skylark_mem_arbiter: per-cycle vector table plus timeout and reset sequences.
module tb_skylark_mem_arbiter;
  logic clk = 1'b0;
  logic reset;

  skylark_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  skylark_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef logic [133:0] ov_t;

  typedef struct {
    logic        ifr;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        rdy;
    logic [31:0] mrd;
    ov_t         exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic ov_t mk(input logic mreq, input logic mwe, input logic [31:0] maddr,
                             input logic [31:0] mwd, input logic ifv, input logic ife,
                             input logic [31:0] ifd, input logic dv, input logic de,
                             input logic [31:0] dd);
    return {mreq, mwe, maddr, mwd, ifv, ife, ifd, dv, de, dd};
  endfunction

  function automatic ov_t outs();
    return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_valid, bus.if_err,
            bus.if_rdata, bus.d_valid, bus.d_err, bus.d_rdata};
  endfunction

  task automatic add(input logic ifr, input logic [31:0] ia, input logic dr, input logic dwe,
                     input logic [31:0] da, input logic [31:0] dwd, input logic rdy,
                     input logic [31:0] mrd, input ov_t exp);
    vec_t v;
    v.ifr = ifr; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.rdy = rdy; v.mrd = mrd; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input ov_t act, input ov_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {req,we,addr,wdata,ifv,ife,ifd,dv,de,dd}=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [31:0] ia, input logic dr, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd, input logic rdy,
                       input logic [31:0] mrd);
    bus.if_req = ifr; bus.if_addr = ia; bus.d_req = dr; bus.d_we = dwe;
    bus.d_addr = da; bus.d_wdata = dwd; bus.mem_ready = rdy; bus.mem_rdata = mrd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch at ia with mem_ready low for 15 waiting cycles; ready_last raises mem_ready in the 16th.
  task automatic fetch_watchdog(input string nm, input logic [31:0] ia, input logic ready_last,
                                input logic [31:0] mwd, input logic [31:0] ifd_old,
                                input logic [31:0] dd);
    drive(1, ia, 0, 0, 0, 0, 0, 0);
    step();
    chk({nm, "_grant"}, outs(), mk(1, 0, ia, mwd, 0, 0, ifd_old, 0, 0, dd));
    for (int k = 2; k <= 16; k++) begin
      step();
      chk($sformatf("%s_wait%0d", nm, k), outs(), mk(1, 0, ia, mwd, 0, 0, ifd_old, 0, 0, dd));
    end
    drive(1, ia, 0, 0, 0, 0, ready_last, 32'h0000_0077);
    step();
    if (ready_last)
      chk({nm, "_done"}, outs(), mk(0, 0, ia, mwd, 1, 0, 32'h0000_0077, 0, 0, dd));
    else
      chk({nm, "_err"}, outs(), mk(0, 0, ia, mwd, 1, 1, ifd_old, 0, 0, dd));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk({nm, "_pulse_end"}, outs(),
        mk(0, 0, ia, mwd, 0, 0, ready_last ? 32'h0000_0077 : ifd_old, 0, 0, dd));
  endtask

  initial begin
    logic        qi;
    logic        qd;
    logic [31:0] mwd;
    logic [31:0] ifd;
    logic [31:0] dd;

    // Basic fetch, masked held request, ready ignored in IDLE
    add(1, 'h10, 0, 0, 0, 0, 0, 0,           mk(1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0));
    add(1, 'h10, 0, 0, 0, 0, 1, 'h00A00093,  mk(0, 0, 'h10, 0, 1, 0, 'h00A00093, 0, 0, 0));
    add(1, 'h10, 0, 0, 0, 0, 1, 'h55,        mk(0, 0, 'h10, 0, 0, 0, 'h00A00093, 0, 0, 0));
    // Store with one wait cycle: d_rdata untouched
    add(0, 0, 1, 1, 'h200, 'hDEADBEEF, 0, 0, mk(1, 1, 'h200, 'hDEADBEEF, 0, 0, 'h00A00093, 0, 0, 0));
    add(0, 0, 1, 1, 'h200, 'hDEADBEEF, 0, 0, mk(1, 1, 'h200, 'hDEADBEEF, 0, 0, 'h00A00093, 0, 0, 0));
    add(0, 0, 1, 1, 'h200, 'hDEADBEEF, 1, 'h12345678,
        mk(0, 0, 'h200, 'hDEADBEEF, 0, 0, 'h00A00093, 1, 0, 0));
    add(0, 0, 1, 1, 'h200, 'hDEADBEEF, 0, 0, mk(0, 0, 'h200, 'hDEADBEEF, 0, 0, 'h00A00093, 0, 0, 0));
    // Load
    add(0, 0, 1, 0, 'h300, 'hCAFEF00D, 0, 0, mk(1, 0, 'h300, 'hCAFEF00D, 0, 0, 'h00A00093, 0, 0, 0));
    add(0, 0, 1, 0, 'h300, 'hCAFEF00D, 1, 'hA5A5A5A5,
        mk(0, 0, 'h300, 'hCAFEF00D, 0, 0, 'h00A00093, 1, 0, 'hA5A5A5A5));
    add(0, 0, 0, 0, 0, 0, 0, 0,              mk(0, 0, 'h300, 'hCAFEF00D, 0, 0, 'h00A00093, 0, 0, 'hA5A5A5A5));
    // Contention with three wait cycles per access
`ifdef SKYLARK_ARB_RR_EN
    for (int k = 0; k < 4; k++)
      add(1, 'h40, 1, 0, 'h400, 0, 0, 0, mk(1, 0, 'h40, 'hCAFEF00D, 0, 0, 'h00A00093, 0, 0, 'hA5A5A5A5));
    add(1, 'h40, 1, 0, 'h400, 0, 1, 'h11111111,
        mk(0, 0, 'h40, 'hCAFEF00D, 1, 0, 'h11111111, 0, 0, 'hA5A5A5A5));
    add(1, 'h40, 1, 0, 'h400, 0, 0, 0, mk(1, 0, 'h400, 0, 0, 0, 'h11111111, 0, 0, 'hA5A5A5A5));
    qi = 1'b0; qd = 1'b1;
    for (int k = 0; k < 3; k++)
      add(qi, 'h40, qd, 0, 'h400, 0, 0, 0, mk(1, 0, 'h400, 0, 0, 0, 'h11111111, 0, 0, 'hA5A5A5A5));
    add(qi, 'h40, qd, 0, 'h400, 0, 1, 'h22222222,
        mk(0, 0, 'h400, 0, 0, 0, 'h11111111, 1, 0, 'h22222222));
    add(0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 'h400, 0, 0, 0, 'h11111111, 0, 0, 'h22222222));
`else
    for (int k = 0; k < 4; k++)
      add(1, 'h40, 1, 0, 'h400, 0, 0, 0, mk(1, 0, 'h400, 0, 0, 0, 'h00A00093, 0, 0, 'hA5A5A5A5));
    add(1, 'h40, 1, 0, 'h400, 0, 1, 'h11111111,
        mk(0, 0, 'h400, 0, 0, 0, 'h00A00093, 1, 0, 'h11111111));
    add(1, 'h40, 1, 0, 'h400, 0, 0, 0, mk(1, 0, 'h40, 0, 0, 0, 'h00A00093, 0, 0, 'h11111111));
    qi = 1'b1; qd = 1'b0;
    for (int k = 0; k < 3; k++)
      add(qi, 'h40, qd, 0, 'h400, 0, 0, 0, mk(1, 0, 'h40, 0, 0, 0, 'h00A00093, 0, 0, 'h11111111));
    add(qi, 'h40, qd, 0, 'h400, 0, 1, 'h22222222,
        mk(0, 0, 'h40, 0, 1, 0, 'h22222222, 0, 0, 'h11111111));
    add(0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 'h40, 0, 0, 0, 'h22222222, 0, 0, 'h11111111));
`endif

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_state", outs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ifr, vecs[i].ia, vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dwd,
            vecs[i].rdy, vecs[i].mrd);
      step();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    mwd = vecs[vecs.size()-1].exp[99:68];
    ifd = vecs[vecs.size()-1].exp[65:34];
    dd  = vecs[vecs.size()-1].exp[31:0];

    fetch_watchdog("timeout", 32'h80, 1'b0, mwd, ifd, dd);
    fetch_watchdog("late_ready", 32'h84, 1'b1, mwd, ifd, dd);

    // Reset in the middle of a store
    drive(0, 0, 1, 1, 32'h500, 32'hBEEF0000, 0, 0);
    step();
    chk("rst_store_grant", outs(), mk(1, 1, 'h500, 'hBEEF0000, 0, 0, 'h77, 0, 0, dd));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_clear", outs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 32'hFFFF0000);
    step();
    chk("rst_no_pulse", outs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 32'h90, 0, 0, 0, 0, 0, 0);
    step();
    chk("rst_fetch_grant", outs(), mk(1, 0, 'h90, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 32'h90, 0, 0, 0, 0, 1, 32'h99);
    step();
    chk("rst_fetch_done", outs(), mk(0, 0, 'h90, 0, 1, 0, 'h99, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/skylark_mem_arbiter.md
# skylark_mem_arbiter

Sequencer and arbiter that shares one single-ported, variable-latency memory between the core's instruction-fetch port and its data (load/store) port. It sits between `skylark_core` and the memory model or SoC bus. It serialises the two requesters, holds the memory request until the memory acknowledges, and returns one-cycle response pulses. A watchdog counter aborts any access the memory fails to acknowledge in time.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width.
- `TIMEOUT`, 15, number of additional cycles an access may wait for `mem_ready` before it is aborted (≥1).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_valid`.
- `if_addr`  in  AW  fetch address (PCF).
- `if_rdata`  out  DW  fetched instruction (InstrF).
- `if_valid`  out  1  one-cycle fetch completion pulse.
- `if_err`  out  1  qualifies `if_valid`: access timed out.
- `d_req`  in  1  data request; held until `d_valid`.
- `d_we`  in  1  1 = store (MemWriteW), 0 = load.
- `d_addr`  in  AW  data address (ALUResultW).
- `d_wdata`  in  DW  store data (WriteData).
- `d_rdata`  out  DW  load data (ReadData).
- `d_valid`  out  1  one-cycle data completion pulse.
- `d_err`  out  1  qualifies `d_valid`: access timed out.
- `mem_req`  out  1  memory access active.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid with `mem_ready`.
- `mem_ready`  in  1  memory acknowledge.

## Operation
- The FSM has three states: IDLE, IF_ACC and D_ACC.
- **IDLE**
  - The FSM samples `if_req` and `d_req`.
  - A requester whose `*_valid` is high in the current cycle is masked. This prevents a held request from being re-granted.
  - The winner's address, write data and `we` are registered onto `mem_*`. `mem_req` is set and the FSM moves to IF_ACC or D_ACC.
  - Fetch grants always drive `mem_we = 0`.
- **Priority (default):** data beats fetch on a simultaneous request.
- **IF_ACC / D_ACC**
  - `mem_*` are held stable and the watchdog counter increments each cycle.
  - On `mem_ready`:
    - The FSM clears `mem_req` and `mem_we` and returns to IDLE.
    - It pulses the granted `*_valid` for one cycle.
    - For a fetch or a load, `mem_rdata` is captured into `*_rdata`.
    - For a store, `d_rdata` is unchanged.
- **Timeout:** if the counter equals `TIMEOUT` and `mem_ready` is low:
  - The FSM drops `mem_req` and returns to IDLE.
  - It pulses `*_valid` together with `*_err`.
  - `*_rdata` is unchanged.
  - If `mem_ready` arrives in that same cycle, `mem_ready` wins and no error is raised.
- The watchdog counter is `$clog2(TIMEOUT+1)` bits wide, clears on every grant and saturates.
- `mem_ready` is ignored in IDLE.
- A requester that drops its request before completion does not cancel the access: the access completes and the pulse is still issued.
- **Reset:** asynchronously forces IDLE and clears every output (`mem_*`, `*_valid`, `*_err`, `*_rdata`) and the counter. An in-flight access is abandoned with no response pulse.

## Timing
- Request high in cycle N → IDLE grants at the end of N → `mem_req` high in N+1.
- If `mem_ready` arrives in N+1 → `*_valid` in N+2. The minimum request-to-response latency is 2 cycles.
- Each extra wait cycle adds 1 cycle of latency. The worst case is `TIMEOUT`+2 cycles to the error pulse.
- Back-to-back accesses pass through one IDLE cycle, so peak throughput is one access per 2 cycles.
- `*_rdata` and `*_err` are registered. `*_rdata` holds until the next successful completion on the same port. `*_err` is valid only while `*_valid` is high.

## Configuration
- `SKYLARK_ARB_RR_EN` **defined:** round-robin arbitration.
  - A `last_grant` register resets to "data", so fetch wins the first contest.
  - On a simultaneous request, the requester not granted last wins.
  - A single requester always wins regardless of `last_grant`.
- `SKYLARK_ARB_RR_EN` **undefined:** fixed data-over-fetch priority and no `last_grant` register.

## Test plan
- **Basic fetch:** reset, then `if_req=1` with `if_addr=0x10` and memory acking one cycle later with `0x00A00093` → `mem_req` high with `mem_addr=0x10` and `mem_we=0`; `if_valid` pulses once 2 cycles after the request with `if_rdata=0x00A00093` and `if_err=0`.
- **Store:** `d_req=1`, `d_we=1`, `d_addr=0x200`, `d_wdata=0xDEADBEEF` → `mem_we=1` with those values; `d_valid` pulses; `d_rdata` is unchanged (0 after reset).
- **Contention:** `if_req` and `d_req` rise together, with ready after 3 wait cycles →
  - Without the macro: data is served first, then fetch, with one IDLE cycle between.
  - With `SKYLARK_ARB_RR_EN` and repeated contention: fetch first, then data, alternating.
- **Timeout:** `TIMEOUT=15` with `mem_ready` held low → `mem_req` stays high for 16 cycles, then `if_valid=1` and `if_err=1` for one cycle, and `if_rdata` keeps its old value. A second run with `mem_ready` asserted in the 16th cycle → no error.
- **Reset mid-access:** assert `reset` during D_ACC → `mem_req` drops immediately, no `d_valid` is issued, and a fetch request after reset is granted normally.
